// File: rtl/canal_pkg.sv
// Shared canal-lock types: gate controller state encoding and default dwell length.
package canal_pkg;
  typedef enum logic [1:0] {IDLE, ARRIVED, OPEN, DONE} gate_state_t;
  localparam int ENTER_CYCLES_DEF = 4;
endpackage

// File: rtl/dwell_counter.sv
// Saturating dwell counter: clear wins over enable, stops at ENTER_CYCLES.
module dwell_counter #(
  parameter  int ENTER_CYCLES = 4,
  localparam int W            = $clog2(ENTER_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_done
);
  logic [W-1:0] r_cnt;
  logic         w_done;

  assign w_done = (r_cnt == W'(ENTER_CYCLES));

  always_ff @(posedge clk) begin
    if (i_clr)
      r_cnt <= '0;
    else if (i_en && !w_done)
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt  = r_cnt;
  assign o_done = w_done;
endmodule

// File: rtl/entry_gate.sv
// Canal lock entry-gate controller. Optional macro ENTRY_GATE_INTERLOCK_EN drops
// the gate back to ARRIVED whenever chamber water falls while gate 1 is open.
module entry_gate import canal_pkg::*; #(
  parameter int ENTER_CYCLES = ENTER_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic arr_sw,
  input  logic gate1_sw,
  input  logic water_high,
  input  logic exited,
  output logic arr_li,
  output logic gate1_li,
  output logic occupied,
  output logic entered
);
  localparam int W = $clog2(ENTER_CYCLES + 1);

  gate_state_t  r_ps;
  logic         r_occupied;
  logic [W-1:0] w_cnt;
  logic         w_done;
  logic         w_interlock;

`ifdef ENTRY_GATE_INTERLOCK_EN
  assign w_interlock = (r_ps == OPEN) && !water_high;
`else
  assign w_interlock = 1'b0;
`endif

  dwell_counter #(.ENTER_CYCLES(ENTER_CYCLES)) u_dwell (
    .clk    (clk),
    .i_clr  (reset || (r_ps != OPEN) || w_interlock),
    .i_en   ((r_ps == OPEN) && gate1_sw),
    .o_cnt  (w_cnt),
    .o_done (w_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ps <= IDLE;
    end else begin
      case (r_ps)
        IDLE:    if (arr_sw && !r_occupied) r_ps <= ARRIVED;
        ARRIVED: if (water_high && gate1_sw) r_ps <= OPEN;
        OPEN: begin
          // Water interlock outranks a completed dwell.
          if (w_interlock)                          r_ps <= ARRIVED;
          else if (w_done && !arr_sw && !gate1_sw) r_ps <= DONE;
        end
        DONE:    r_ps <= IDLE;
        default: r_ps <= IDLE;
      endcase
    end
  end

  // Entry completion beats a coincident exit pulse.
  always_ff @(posedge clk) begin
    if (reset)              r_occupied <= 1'b0;
    else if (r_ps == DONE)  r_occupied <= 1'b1;
    else if (exited)        r_occupied <= 1'b0;
  end

  assign arr_li   = arr_sw && !r_occupied;
  assign gate1_li = (r_ps == OPEN);
  assign entered  = (r_ps == DONE);
  assign occupied = r_occupied;
endmodule

// File: tb/tb_entry_gate.sv
// Directed bench for entry_gate with ENTER_CYCLES = 4; expected values hand-derived.
module tb_entry_gate;
  logic clk = 1'b0;
  logic reset, arr_sw, gate1_sw, water_high, exited;
  logic arr_li, gate1_li, occupied, entered;
  int   n_chk = 0;
  int   n_err = 0;
  int   g_cnt;
  int   e_cnt;

  localparam int S_IDLE = 0, S_ARR = 1, S_OPEN = 2, S_DONE = 3;

  entry_gate #(.ENTER_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .arr_sw(arr_sw), .gate1_sw(gate1_sw),
    .water_high(water_high), .exited(exited), .arr_li(arr_li),
    .gate1_li(gate1_li), .occupied(occupied), .entered(entered)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ps();
    return int'(dut.r_ps);
  endfunction

  function automatic int cnt();
    return int'(dut.w_cnt);
  endfunction

  initial begin
    reset = 1; arr_sw = 1; gate1_sw = 0; water_high = 0; exited = 0;
    // 1. reset held two cycles; arr_li follows arr_sw throughout
    tick(); tick();
    chk("rst_ps", ps(), S_IDLE);
    chk("rst_cnt", cnt(), 0);
    chk("rst_occ", occupied, 0);
    chk("rst_g1", gate1_li, 0);
    chk("rst_ent", entered, 0);
    chk("rst_arrli", arr_li, 1);

    // 2. normal entry
    reset = 0;
    tick();
    chk("ne_arr", ps(), S_ARR);
    arr_sw = 0; water_high = 1; gate1_sw = 1;
    tick();
    chk("ne_open", ps(), S_OPEN);
    chk("ne_cnt0", cnt(), 0);
    g_cnt = gate1_li;
    for (int i = 0; i < 4; i++) begin
      tick();
      g_cnt += gate1_li;
    end
    chk("ne_cnt_sat", cnt(), 4);
    gate1_sw = 0;
    tick();
    g_cnt += gate1_li;
    chk("ne_done", ps(), S_DONE);
    chk("ne_ent", entered, 1);
    chk("ne_occ_pre", occupied, 0);
    chk("ne_g1_cycles", g_cnt, 5);
    tick();
    chk("ne_idle", ps(), S_IDLE);
    chk("ne_ent_end", entered, 0);
    chk("ne_occ", occupied, 1);

    // 4. occupied lockout then exit release
    arr_sw = 1;
    #1 chk("lk_arrli", arr_li, 0);
    tick();
    chk("lk_idle", ps(), S_IDLE);
    exited = 1;
    tick();
    exited = 0;
    #1;
    chk("lk_occ_clr", occupied, 0);
    chk("lk_arrli1", arr_li, 1);
    tick();
    chk("lk_arr", ps(), S_ARR);

    // 5. water not high keeps ARRIVED
    water_high = 0; gate1_sw = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("wl_arr", ps(), S_ARR);
    chk("wl_g1", gate1_li, 0);
    water_high = 1;
    tick();
    chk("wl_open", ps(), S_OPEN);

    // 3. early close: 2 high, 3 low, 2 high, then release
    arr_sw = 0;
    e_cnt = 0;
    tick(); tick();
    chk("ec_cnt2", cnt(), 2);
    gate1_sw = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      e_cnt += entered;
    end
    chk("ec_hold_cnt", cnt(), 2);
    chk("ec_hold_ps", ps(), S_OPEN);
    gate1_sw = 1;
    tick(); tick();
    chk("ec_cnt4", cnt(), 4);
    gate1_sw = 0;
    tick();
    e_cnt += entered;
    chk("ec_done", ps(), S_DONE);
    exited = 1;  // coincident with leaving DONE: set must win
    tick();
    exited = 0;
    e_cnt += entered;
    chk("ec_ent_once", e_cnt, 1);
    chk("ec_occ_setwins", occupied, 1);

    // exit clears occupancy; a stray exit while empty is ignored
    exited = 1; tick(); exited = 0;
    chk("ex_clr", occupied, 0);
    exited = 1; tick(); exited = 0;
    chk("ex_ignored", occupied, 0);
    chk("ex_ps", ps(), S_IDLE);

    // 6. reset while OPEN with cnt = 2
    arr_sw = 1; gate1_sw = 1; water_high = 1;
    tick();
    chk("r6_arr", ps(), S_ARR);
    arr_sw = 0;
    tick(); tick(); tick();
    chk("r6_cnt2", cnt(), 2);
    reset = 1;
    tick();
    reset = 0;
    chk("r6_ps", ps(), S_IDLE);
    chk("r6_cnt", cnt(), 0);
    chk("r6_g1", gate1_li, 0);

    // water drop while OPEN
    arr_sw = 1;
    tick();
    arr_sw = 0;
    tick();
    tick();
    chk("wd_cnt1", cnt(), 1);
    water_high = 0;
    tick();
`ifdef ENTRY_GATE_INTERLOCK_EN
    chk("wd_ps", ps(), S_ARR);
    chk("wd_g1", gate1_li, 0);
    chk("wd_cnt", cnt(), 0);
`else
    chk("wd_ps", ps(), S_OPEN);
    chk("wd_g1", gate1_li, 1);
    chk("wd_cnt", cnt(), 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/entry_gate.md
# entry_gate

- Controls the first (entry) gate of the canal lock: accepts an arriving boat, opens gate 1 once the chamber water is high, and holds the gate open for a minimum dwell time.
- Declares the lock occupied when the boat has entered and the gate is closed.
- Sits upstream of the exit-gate controller: its `occupied` output feeds that controller, and that controller's `exited` pulse feeds back here to release the chamber.

## Interface
- `ENTER_CYCLES`, default 4: minimum cycles gate 1 is held open (with `gate1_sw` high) before entry may complete; legal range ≥1.
- `clk`  in  1  system clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `arr_sw`  in  1  arrival switch; boat requesting entry.
- `gate1_sw`  in  1  operator gate-1 open switch.
- `water_high`  in  1  chamber water at upstream level (from water-level block).
- `exited`  in  1  one-cycle pulse from exit-gate controller; boat has left.
- `arr_li`  out  1  arrival light.
- `gate1_li`  out  1  gate 1 open indicator.
- `occupied`  out  1  registered chamber-occupied flag.
- `entered`  out  1  one-cycle pulse; entry complete.

## Operation
- States: IDLE, ARRIVED, OPEN, DONE.
  - IDLE → ARRIVED when `arr_sw & ~occupied`; else stay.
  - ARRIVED → OPEN when `water_high & gate1_sw`; else stay.
  - OPEN → DONE when `cnt == ENTER_CYCLES & ~arr_sw & ~gate1_sw`; else stay.
  - DONE → IDLE unconditionally.
- Dwell counter `cnt`:
  - Width `$clog2(ENTER_CYCLES+1)`.
  - Cleared whenever state ≠ OPEN.
  - In OPEN, increments each cycle `gate1_sw` is high; saturates at `ENTER_CYCLES`, no wrap.
  - Holds its value while `gate1_sw` is low.
- Early close: if `gate1_sw` drops before saturation, stay in OPEN; the counter resumes when `gate1_sw` is raised again.
- `occupied` register:
  - Set on the edge leaving DONE.
  - Cleared on any edge where `exited` = 1 and the state is not DONE.
  - Set wins if both occur on the same edge.
  - `exited` while `occupied` = 0 is ignored.
- Outputs:
  - `arr_li = arr_sw & ~occupied` (combinational).
  - `gate1_li = (ps == OPEN)`.
  - `entered = (ps == DONE)`.

## Timing
- Reset: state IDLE, `cnt` = 0, `occupied` = 0, `gate1_li` = 0, `entered` = 0. `arr_li` follows `arr_sw` during and after reset.
- `reset` asserted mid-operation (any state) returns the block to IDLE on the next edge and clears `occupied`.
- Latency:
  - Arrival to ARRIVED: 1 edge.
  - ARRIVED to `gate1_li` high: 1 edge after the condition.
  - Minimum time in OPEN: `ENTER_CYCLES` + 1 cycles.
  - `entered` pulse: exactly 1 cycle.
  - `occupied` rises on the edge that ends the `entered` pulse.
- `water_high` is sampled only for the ARRIVED → OPEN transition, unless the interlock is built in (see Configuration).

## Configuration
- Macro: `ENTRY_GATE_INTERLOCK_EN`.
- Defined: in OPEN, `water_high` = 0 forces OPEN → ARRIVED on the next edge, `cnt` clears, and `gate1_li` drops. This interlock has priority over the OPEN → DONE transition.
- Undefined: once in OPEN, `water_high` is ignored.

## Structure
- Shared package `canal_pkg`:
  - Gate state enum (IDLE, ARRIVED, OPEN, DONE).
  - Default `ENTER_CYCLES` constant.
- Sub-module `dwell_counter`: saturating counter with clear, enable and `done` output, parameterised by `ENTER_CYCLES`.

## Test plan
All scenarios use `ENTER_CYCLES` = 4.
1. Reset held 2 cycles → state IDLE, `occupied` = 0, `gate1_li` = 0, `entered` = 0.
2. Normal entry:
   - Stimulus: `arr_sw` = 1, then `water_high` = 1 and `gate1_sw` = 1 for 4 cycles, then both switches low.
   - Response: `gate1_li` high for 5 cycles, one `entered` pulse, `occupied` = 1 on the following cycle.
3. Early close:
   - Stimulus: `gate1_sw` high 2 cycles, low 3, high 2, then both switches low.
   - Response: no DONE until `cnt` = 4; `entered` pulses once.
4. Occupied lockout:
   - Stimulus: `occupied` = 1, `arr_sw` = 1.
   - Response: `arr_li` = 0 and the state stays IDLE.
   - Stimulus: `exited` pulse.
   - Response: `occupied` = 0 next cycle; `arr_li` = 1.
5. Water not high:
   - Stimulus: ARRIVED with `gate1_sw` = 1, `water_high` = 0 for 5 cycles.
   - Response: stays ARRIVED, `gate1_li` = 0.
   - With `ENTRY_GATE_INTERLOCK_EN`, dropping `water_high` in OPEN returns the block to ARRIVED next cycle.
6. Reset asserted in OPEN with `cnt` = 2 → IDLE, `cnt` = 0, `gate1_li` = 0 next cycle.
